pcileech_pcie_cfg_engine: RTL

Single-clock PCIe configuration-space command engine. It sits in the PCIe clock domain between the host command/response FIFOs and the PCIe core cfg management port. It generalises the existing cfg handler with several additions:
- parametrised address width;
- multi-dword burst reads with address wrap;
- optional write acknowledgements;
- a per-access timeout with error reporting;
- valid/ready backpressure on both sides.

---
 rtl/pcileech_pcie_cfg_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pcileech_pcie_cfg_engine.sv
// pcileech_pcie_cfg_engine
// Configuration-space command engine in the PCIe core clock domain. Takes
// 64-bit commands from the host FIFO (STATUS, READ with burst, WRITE), drives
// the core cfg management port, and returns 64-bit response words.
//
// Handshakes: a transfer happens on the rising clk edge where valid & ready
// are both high. A producer holds valid and its data unchanged until that
// edge. A consumer may hold ready low for any number of cycles. cmd_ready is
// high only in IDLE. rsp_valid is high in STATUS/RSP, and rsp_data is frozen
// while it is high.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_data/cmd_valid/cmd_ready  command stream in
//   rsp_data/rsp_valid/rsp_ready  response stream out
//   busy                          engine not in IDLE
//   cfg_bus/device/function_number, cfg_command   core identity for STATUS
//   cfg_do, cfg_rd_wr_done        core read data / access complete
//   cfg_dwaddr, cfg_rd_en, cfg_di, cfg_wr_en, cfg_byte_en   core access
//
// Debug: the FSM register `state` (type state_t) is visible hierarchically.
module pcileech_pcie_cfg_engine #(
  parameter int ADDR_W         = 10,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WR_ACK         = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [63:0]       rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              busy,
  input  logic [7:0]        cfg_bus_number,
  input  logic [4:0]        cfg_device_number,
  input  logic [2:0]        cfg_function_number,
  input  logic [15:0]       cfg_command,
  input  logic [31:0]       cfg_do,
  input  logic              cfg_rd_wr_done,
  output logic [ADDR_W-1:0] cfg_dwaddr,
  output logic              cfg_rd_en,
  output logic [31:0]       cfg_di,
  output logic              cfg_wr_en,
  output logic [3:0]        cfg_byte_en
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STATUS, S_RD_REQ, S_WR_REQ, S_RSP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       di_r;
  logic [3:0]        be_r;
  logic [CNT_W-1:0]  beats_left;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        err_cnt;
  logic [63:0]       rsp_data_r;
  logic              rd_en_r, wr_en_r, err_r, run_r;

  logic              accept, in_req, to_hit, req_end, more_beats;
  logic [3:0]        cmd_type, req_type;
  logic [31:0]       req_data;
  logic [63:0]       status_word;
  logic              unused_cmd;

  assign unused_cmd  = ^cmd_data;
  assign cmd_type    = cmd_data[3:0];
  assign accept      = cmd_valid & cmd_ready;
  assign in_req      = (state == S_RD_REQ) || (state == S_WR_REQ);
  // done has priority: a timeout is only declared in a cycle without done.
  assign to_hit      = in_req && (to_cnt == TO_LAST) && !cfg_rd_wr_done;
  assign req_end     = cfg_rd_wr_done || to_hit;
  assign more_beats  = (beats_left != '0) && !err_r;
  assign req_type    = (state == S_RD_REQ) ? 4'd1 : 4'd2;
  assign req_data    = to_hit ? 32'hFFFF_FFFF :
                       (state == S_RD_REQ) ? cfg_do : 32'h0;
  assign status_word = {8'h00, err_cnt, cfg_command, cfg_function_number,
                        cfg_device_number, cfg_bus_number, 8'h77, 8'h00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_type)
            4'd0:    state_nxt = S_STATUS;
            4'd1:    state_nxt = S_RD_REQ;
            4'd2:    state_nxt = S_WR_REQ;
            default: state_nxt = S_IDLE;   // unknown types are dropped
          endcase
        end
      end
      S_RD_REQ: if (req_end) state_nxt = S_RSP;
      S_WR_REQ: if (req_end) state_nxt = (WR_ACK != 0) ? S_RSP : S_IDLE;
      // STATUS already presents its response, so it can complete directly.
      S_STATUS, S_RSP: begin
        if (rsp_ready) state_nxt = more_beats ? S_RD_REQ : S_IDLE;
        else           state_nxt = S_RSP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready   = (state == S_IDLE) && run_r;
    rsp_valid   = (state == S_STATUS) || (state == S_RSP);
    rsp_data    = rsp_data_r;
    busy        = (state != S_IDLE);
    cfg_rd_en   = rd_en_r & ~cfg_rd_wr_done;
    cfg_wr_en   = wr_en_r & ~cfg_rd_wr_done;
    cfg_dwaddr  = addr_r;
    cfg_di      = di_r;
    cfg_byte_en = be_r;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      di_r       <= '0;
      be_r       <= '0;
      beats_left <= '0;
      to_cnt     <= '0;
      err_cnt    <= '0;
      rsp_data_r <= '0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      err_r      <= 1'b0;
      run_r      <= 1'b0;   // keeps cmd_ready low until reset is released
    end else begin
      run_r <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd_type)
              4'd0: begin
                rsp_data_r <= status_word;
                beats_left <= '0;
              end
              4'd1: begin
                addr_r     <= cmd_data[16 +: ADDR_W];
                be_r       <= cmd_data[7:4];
                beats_left <= cmd_data[8 +: CNT_W];
                to_cnt     <= '0;
                err_r      <= 1'b0;
                rd_en_r    <= 1'b1;
              end
              4'd2: begin
                addr_r     <= cmd_data[16 +: ADDR_W];
                be_r       <= cmd_data[7:4];
                di_r       <= cmd_data[63:32];
                beats_left <= '0;
                to_cnt     <= '0;
                err_r      <= 1'b0;
                wr_en_r    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (req_end) begin
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            err_r      <= to_hit;
            rsp_data_r <= {req_data, 16'(addr_r), 8'h77, 3'b000, to_hit, req_type};
            if (to_hit && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RSP: begin
          // Next burst beat starts only after the previous response is taken.
          if (rsp_ready && more_beats) begin
            addr_r     <= addr_r + 1'b1;
            beats_left <= beats_left - 1'b1;
            to_cnt     <= '0;
            rd_en_r    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
